// File: rtl/pipe_pkg.sv
// pipe_pkg: decode control bundle and nop constants shared by the front-end pipeline registers
package pipe_pkg;
    typedef struct packed {
        logic       RegWrite;
        logic       MemtoReg;
        logic       MemWrite;
        logic [2:0] ALUControl;
        logic       ALUSrc;
        logic       RegDst;
    } ctrl_t;
    localparam ctrl_t       CTRL_NOP  = '0;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: W-bit register, async active-low reset to RST, hold when en=0, sync clear (to 0) when en=1 and clr=1
//   clk, reset (active-low, async), en, clr, d[W-1:0] -> q[W-1:0]
module pipe_reg #(
    parameter int             W   = 32,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= RST;
        else if (en) q <= clr ? '0 : d;
endmodule

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers with stall/flush/redirect handling
//   in : clk, reset (active-low, async), PCNextF, InstrF, PCPlus4F, StallF, StallD, FlushE,
//        RedirectD, CtrlD, RD1D, RD2D, SignImmD, rsD, rtD, rdD
//   out: PCF, InstrD, PCPlus4D, ValidD, CtrlE, RD1E, RD2E, SignImmE, rsE, rtE, rdE, ValidE,
//        StallCnt, FlushCnt (live only when PIPE_PERF_EN is defined, else constant 0)
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PCNextF,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      PCPlus4F,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             RedirectD,
    input  ctrl_t            CtrlD,
    input  logic [31:0]      RD1D,
    input  logic [31:0]      RD2D,
    input  logic [31:0]      SignImmD,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rdD,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output ctrl_t            CtrlE,
    output logic [31:0]      RD1E,
    output logic [31:0]      RD2E,
    output logic [31:0]      SignImmE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       rdE,
    output logic             ValidE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);
    localparam int FD_W = 32 + 32 + 1;
    localparam int DE_W = $bits(ctrl_t) + 3 * 32 + 3 * 5 + 1;

    logic [FD_W-1:0] fd_q;
    logic [DE_W-1:0] de_q;

    pipe_reg #(.W(32), .RST(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(!StallF), .clr(1'b0), .d(PCNextF), .q(PCF)
    );

    // redirect clears to INSTR_NOP (all zero) with ValidD=0; stall has priority via en
    pipe_reg #(.W(FD_W)) u_fd (
        .clk(clk), .reset(reset), .en(!StallD), .clr(RedirectD),
        .d({InstrF, PCPlus4F, 1'b1}), .q(fd_q)
    );
    assign {InstrD, PCPlus4D, ValidD} = fd_q;

    // ID/EX never stalls; a flush zeroes CtrlE (CTRL_NOP) and ValidE
    pipe_reg #(.W(DE_W)) u_de (
        .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE),
        .d({CtrlD, RD1D, RD2D, SignImmD, rsD, rtD, rdD, ValidD}), .q(de_q)
    );
    assign {CtrlE, RD1E, RD2E, SignImmE, rsE, rtE, rdE, ValidE} = de_q;

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
            if (RedirectD && !StallD && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
        end
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed self-checking bench for pipe_front_regs
module tb_pipe_front_regs;
    import pipe_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD;
    logic        StallF, StallD, FlushE, RedirectD;
    ctrl_t       CtrlD;
    logic [4:0]  rsD, rtD, rdD;
    logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
    logic        ValidD, ValidE;
    ctrl_t       CtrlE;
    logic [4:0]  rsE, rtE, rdE;
    logic [3:0]  StallCnt, FlushCnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;
    logic [3:0]  exp_flush;

    pipe_front_regs #(.RESET_PC(RST_PC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .RedirectD(RedirectD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .ValidE(ValidE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {StallF, StallD, FlushE, RedirectD} = '0;
        {PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD} = '0;
        CtrlD = '0;
        {rsD, rtD, rdD} = '0;
        #12;
        checks++; if (PCF !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", PCF, RST_PC); end
        checks++; if ({ValidD, ValidE} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", {ValidD, ValidE}); end
        checks++; if ({InstrD, CtrlE, RD1E} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", InstrD, CtrlE, RD1E); end
        checks++; if ({StallCnt, FlushCnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", {StallCnt, FlushCnt}); end
        reset = 1'b1;
        exp_pc = RST_PC;
        exp_flush = 4'h0;
    endtask

    task automatic test_free_run();
        InstrF = 32'h2008_0005;
        PCPlus4F = exp_pc + 4;
        PCNextF = exp_pc + 4;
        CtrlD = ctrl_t'(8'hA5);
        RD1D = 32'h1111_2222; RD2D = 32'h3333_4444; SignImmD = 32'hFFFF_FFF5;
        rsD = 5'd8; rtD = 5'd9; rdD = 5'd10;
        step();
        exp_pc = exp_pc + 4;
        checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL run_pc got %h exp %h", PCF, exp_pc); end
        checks++; if ({InstrD, PCPlus4D, ValidD} !== {32'h2008_0005, exp_pc, 1'b1}) begin errors++; $display("FAIL run_ifid got %h %h %b exp 20080005 %h 1", InstrD, PCPlus4D, ValidD, exp_pc); end
        checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL run_valide0 got %b exp 0", ValidE); end
        PCNextF = exp_pc + 4;
        PCPlus4F = exp_pc + 4;
        step();
        exp_pc = exp_pc + 4;
        checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL run_valide1 got %b exp 1", ValidE); end
        checks++; if ({CtrlE, RD1E, RD2E, SignImmE} !== {8'hA5, 32'h1111_2222, 32'h3333_4444, 32'hFFFF_FFF5}) begin errors++; $display("FAIL run_idex_data got %h %h %h %h", CtrlE, RD1E, RD2E, SignImmE); end
        checks++; if ({rsE, rtE, rdE} !== {5'd8, 5'd9, 5'd10}) begin errors++; $display("FAIL run_idex_regs got %0d %0d %0d exp 8 9 10", rsE, rtE, rdE); end
    endtask

    task automatic test_stall_flush();
        {StallF, StallD, FlushE} = 3'b111;
        InstrF = 32'hDEAD_BEEF;
        PCNextF = 32'h0000_0999;
        step();
        checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL stall_pc got %h exp %h", PCF, exp_pc); end
        checks++; if ({InstrD, ValidD} !== {32'h2008_0005, 1'b1}) begin errors++; $display("FAIL stall_ifid got %h %b exp 20080005 1", InstrD, ValidD); end
        checks++; if ({CtrlE, ValidE, RD1E, rsE} !== '0) begin errors++; $display("FAIL stall_bubble got ctrl %h valid %b rd1 %h rs %0d exp 0", CtrlE, ValidE, RD1E, rsE); end
        checks++; if (StallCnt !== (PERF ? 4'd1 : 4'd0)) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", StallCnt, PERF ? 1 : 0); end
        {StallF, StallD, FlushE} = 3'b000;
        PCNextF = exp_pc + 4;
        step();
        exp_pc = exp_pc + 4;
        checks++; if ({PCF, InstrD} !== {exp_pc, 32'hDEAD_BEEF}) begin errors++; $display("FAIL resume got %h %h exp %h deadbeef", PCF, InstrD, exp_pc); end
        checks++; if ({ValidE, CtrlE} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL resume_e got %b %h exp 1 a5", ValidE, CtrlE); end
    endtask

    task automatic test_redirect();
        RedirectD = 1'b1;
        PCNextF = 32'h0000_0040;
        step();
        exp_pc = 32'h0000_0040;
        exp_flush = exp_flush + 1;
        checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL redir_pc got %h exp 00000040", PCF); end
        checks++; if ({InstrD, PCPlus4D, ValidD} !== '0) begin errors++; $display("FAIL redir_ifid got %h %h %b exp 0", InstrD, PCPlus4D, ValidD); end
        checks++; if (FlushCnt !== (PERF ? exp_flush : 4'd0)) begin errors++; $display("FAIL redir_cnt got %0d exp %0d", FlushCnt, PERF ? exp_flush : 4'd0); end
        RedirectD = 1'b0;
        InstrF = 32'h0123_4567;
        PCNextF = exp_pc + 4;
        step();
        exp_pc = exp_pc + 4;
        checks++; if ({ValidE, ValidD, InstrD} !== {1'b0, 1'b1, 32'h0123_4567}) begin errors++; $display("FAIL redir_follow got %b %b %h exp 0 1 01234567", ValidE, ValidD, InstrD); end
    endtask

    task automatic test_redirect_stall();
        {StallF, StallD, RedirectD} = 3'b111;
        InstrF = 32'hCAFE_0000;
        PCNextF = 32'h0000_0080;
        step();
        checks++; if (PCF !== exp_pc) begin errors++; $display("FAIL rstall_pc got %h exp %h", PCF, exp_pc); end
        checks++; if ({InstrD, ValidD} !== {32'h0123_4567, 1'b1}) begin errors++; $display("FAIL rstall_ifid got %h %b exp 01234567 1", InstrD, ValidD); end
        checks++; if (FlushCnt !== (PERF ? exp_flush : 4'd0)) begin errors++; $display("FAIL rstall_cnt got %0d exp %0d", FlushCnt, PERF ? exp_flush : 4'd0); end
    endtask

    task automatic test_async_reset();
        RedirectD = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (PCF !== RST_PC) begin errors++; $display("FAIL areset_pc got %h exp %h", PCF, RST_PC); end
        checks++; if ({ValidD, ValidE} !== 2'b00) begin errors++; $display("FAIL areset_valid got %b exp 00", {ValidD, ValidE}); end
        checks++; if ({StallCnt, FlushCnt} !== 8'h00) begin errors++; $display("FAIL areset_cnt got %h exp 00", {StallCnt, FlushCnt}); end
    endtask

    task automatic test_perf_sat();
        {StallF, StallD} = 2'b01;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++; if (StallCnt !== (PERF ? 4'hF : 4'h0)) begin errors++; $display("FAIL perf_sat got %h exp %h", StallCnt, PERF ? 4'hF : 4'h0); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL perf_validd got %b exp 0", ValidD); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_flush();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        test_perf_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
